// File: rtl/snoopy_bus_arbiter_pkg.sv
// Shared types and helpers for the snoopy bus arbiter and the round-robin
// arbiters elsewhere in the memory subsystem.
package snoopy_bus_arbiter_pkg;

    localparam int MAX_CACHES   = 16;
    localparam int MAX_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        SNOOP,
        RELEASE
    } arbState_e;

    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] index;
    } rrPick_t;

    // First set request bit scanning pointer, pointer+1, ... modulo count.
    function automatic rrPick_t round_robin_pick(
        input logic [MAX_CACHES-1:0]   request,
        input logic [MAX_ID_WIDTH-1:0] pointer,
        input int unsigned             count
    );
        rrPick_t     pick;
        int unsigned idx;
        pick = '0;
        for (int unsigned i = 0; i < count; i++) begin
            idx = 32'(pointer) + i;
            if (idx >= count) idx = idx - count;
            if (!pick.valid && request[idx[MAX_ID_WIDTH-1:0]]) begin
                pick.valid = 1'b1;
                pick.index = idx[MAX_ID_WIDTH-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [MAX_CACHES-1:0] onehot(input logic [MAX_ID_WIDTH-1:0] index);
        logic [MAX_CACHES-1:0] vec;
        vec        = '0;
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/snoopy_bus_arbiter_if.sv
// Snoopy bus handshake bundle: master = arbiter side, slave = cache side.
interface snoopy_bus_arbiter_if #(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int ID_WIDTH         = (NUMBER_OF_CACHES > 1) ? $clog2(NUMBER_OF_CACHES) : 1
);

    logic [NUMBER_OF_CACHES-1:0] request;
    logic [NUMBER_OF_CACHES-1:0] grant;
    logic                        commandValid;
    logic [NUMBER_OF_CACHES-1:0] snoopRequest;
    logic [NUMBER_OF_CACHES-1:0] snoopDone;
    logic                        commandDone;
    logic                        busBusy;
    logic [ID_WIDTH-1:0]         ownerId;

    modport master (
        input  request, commandValid, snoopDone,
        output grant, snoopRequest, commandDone, busBusy, ownerId
    );

    modport slave (
        output request, commandValid, snoopDone,
        input  grant, snoopRequest, commandDone, busBusy, ownerId
    );

endinterface

// File: rtl/snoopy_bus_arbiter_round_robin_selector.sv
// Combinational round-robin winner selection starting at a priority pointer.
module round_robin_selector
    import snoopy_bus_arbiter_pkg::*;
#(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int ID_WIDTH         = (NUMBER_OF_CACHES > 1) ? $clog2(NUMBER_OF_CACHES) : 1
) (
    input  logic [NUMBER_OF_CACHES-1:0] request,
    input  logic [ID_WIDTH-1:0]         pointer,
    output logic [ID_WIDTH-1:0]         winner,
    output logic                        valid
);

    rrPick_t pick;

    always_comb begin
        pick   = round_robin_pick(MAX_CACHES'(request), MAX_ID_WIDTH'(pointer), NUMBER_OF_CACHES);
        valid  = pick.valid;
        winner = ID_WIDTH'(pick.index);
    end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner of the shared snoopy bus with snoop broadcast/collect.
// Define ARBITER_GRANT_COUNTERS_EN to add saturating per-cache grant counters.
module snoopy_bus_arbiter
    import snoopy_bus_arbiter_pkg::*;
#(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int ID_WIDTH         = (NUMBER_OF_CACHES > 1) ? $clog2(NUMBER_OF_CACHES) : 1,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    snoopy_bus_arbiter_if.master bus
`ifdef ARBITER_GRANT_COUNTERS_EN
    ,
    output logic [NUMBER_OF_CACHES*COUNTER_WIDTH-1:0] grantCount
`endif
);

    if (NUMBER_OF_CACHES < 1 || NUMBER_OF_CACHES > MAX_CACHES || COUNTER_WIDTH < 1) begin : gBadParams
        $error("snoopy_bus_arbiter: illegal parameter values");
    end

    arbState_e                   state;
    logic [NUMBER_OF_CACHES-1:0] grantReg;
    logic [NUMBER_OF_CACHES-1:0] pending;
    logic                        commandDoneReg;
    logic                        busBusyReg;
    logic [ID_WIDTH-1:0]         ownerIdReg;
    logic [ID_WIDTH-1:0]         pointer;
    logic [ID_WIDTH-1:0]         winner;
    logic                        winnerValid;
    logic [NUMBER_OF_CACHES-1:0] pendingNext;

    round_robin_selector #(
        .NUMBER_OF_CACHES(NUMBER_OF_CACHES),
        .ID_WIDTH        (ID_WIDTH)
    ) rrSelector (
        .request(bus.request),
        .pointer(pointer),
        .winner (winner),
        .valid  (winnerValid)
    );

    assign pendingNext = pending & ~bus.snoopDone;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            grantReg       <= '0;
            pending        <= '0;
            commandDoneReg <= 1'b0;
            busBusyReg     <= 1'b0;
            ownerIdReg     <= '0;
            pointer        <= '0;
        end else begin
            commandDoneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (winnerValid) begin
                        ownerIdReg <= winner;
                        grantReg   <= NUMBER_OF_CACHES'(onehot(MAX_ID_WIDTH'(winner)));
                        busBusyReg <= 1'b1;
                        state      <= GRANTED;
                    end
                end
                GRANTED: begin
                    // grantReg is the owner's one-hot, so ~grantReg is every other cache
                    if (bus.commandValid) begin
                        pending <= ~grantReg;
                        state   <= SNOOP;
                    end else if ((bus.request & grantReg) == '0) begin
                        grantReg <= '0;
                        state    <= RELEASE;
                    end
                end
                SNOOP: begin
                    pending <= pendingNext;
                    if (pendingNext == '0) begin
                        commandDoneReg <= 1'b1;
                        state          <= GRANTED;
                    end
                end
                RELEASE: begin
                    pointer    <= (ownerIdReg == ID_WIDTH'(NUMBER_OF_CACHES - 1)) ? '0
                                                                               : ownerIdReg + ID_WIDTH'(1);
                    busBusyReg <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = grantReg;
    assign bus.snoopRequest = pending;
    assign bus.commandDone  = commandDoneReg;
    assign bus.busBusy      = busBusyReg;
    assign bus.ownerId      = ownerIdReg;

`ifdef ARBITER_GRANT_COUNTERS_EN
    logic [NUMBER_OF_CACHES-1:0][COUNTER_WIDTH-1:0] counters;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counters <= '0;
        end else if (state == IDLE && winnerValid) begin
            for (int unsigned i = 0; i < NUMBER_OF_CACHES; i++) begin
                if (winner == ID_WIDTH'(i) && counters[i] != '1) begin
                    counters[i] <= counters[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    assign grantCount = counters;
`endif

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed-vector bench for snoopy_bus_arbiter (N=4); counter checks run when
// ARBITER_GRANT_COUNTERS_EN is defined.
module tb_snoopy_bus_arbiter;

    localparam int N = 4;
`ifdef ARBITER_GRANT_COUNTERS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic clock;
    logic reset;
    int   total;
    int   bad;

    snoopy_bus_arbiter_if #(.NUMBER_OF_CACHES(N)) bus ();

`ifdef ARBITER_GRANT_COUNTERS_EN
    logic [N*CW-1:0] grantCount;
`endif

    snoopy_bus_arbiter #(
        .NUMBER_OF_CACHES(N),
        .COUNTER_WIDTH   (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
`ifdef ARBITER_GRANT_COUNTERS_EN
        ,
        .grantCount(grantCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    logic [3:0] order [5];
    int         ids   [5];

    initial begin
        total = 0;
        bad   = 0;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ids   = '{0, 1, 2, 3, 0};

        reset            = 1'b0;
        bus.request      = '0;
        bus.commandValid = 1'b0;
        bus.snoopDone    = '0;
        tick();
        tick();
        checkValue("rst grant", 32'(bus.grant), 0);
        checkValue("rst snoopRequest", 32'(bus.snoopRequest), 0);
        checkValue("rst commandDone", 32'(bus.commandDone), 0);
        checkValue("rst busBusy", 32'(bus.busBusy), 0);
        checkValue("rst ownerId", 32'(bus.ownerId), 0);
        reset = 1'b1;

        // single requester
        bus.request = 4'b0010;
        #1;
        checkValue("single grant before edge", 32'(bus.grant), 0);
        tick();
        checkValue("single grant", 32'(bus.grant), 32'b0010);
        checkValue("single ownerId", 32'(bus.ownerId), 1);
        checkValue("single busBusy", 32'(bus.busBusy), 1);
        tick();
        checkValue("single grant held", 32'(bus.grant), 32'b0010);
        bus.request = '0;
        tick();
        checkValue("release grant", 32'(bus.grant), 0);
        checkValue("release busBusy", 32'(bus.busBusy), 1);
        tick();
        checkValue("idle busBusy", 32'(bus.busBusy), 0);
        bus.request = 4'b1111;
        tick();
        checkValue("pointer=2 grant", 32'(bus.grant), 32'b0100);
        checkValue("pointer=2 ownerId", 32'(bus.ownerId), 2);

        // reset while granted
        reset = 1'b0;
        #1;
        checkValue("rst granted grant", 32'(bus.grant), 0);
        checkValue("rst granted busBusy", 32'(bus.busBusy), 0);
        tick();
        reset = 1'b1;

        // contention from pointer 0, including wrap 3 -> 0
        bus.request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkValue($sformatf("rr grant %0d", k), 32'(bus.grant), 32'(order[k]));
            checkValue($sformatf("rr ownerId %0d", k), 32'(bus.ownerId), 32'(ids[k]));
            tick();
            checkValue($sformatf("rr hold %0d", k), 32'(bus.grant), 32'(order[k]));
            bus.request = 4'b1111 & ~order[k];
            tick();
            checkValue($sformatf("rr drop %0d", k), 32'(bus.grant), 0);
            tick();
            checkValue($sformatf("rr idle %0d", k), 32'(bus.busBusy), 0);
            bus.request = 4'b1111;
        end
        bus.request = '0;

        // snoop broadcast, owner 2, acks on bits 0, 3, 1
        bus.request = 4'b0100;
        tick();
        checkValue("snoop owner grant", 32'(bus.grant), 32'b0100);
        bus.commandValid = 1'b1;
        tick();
        bus.commandValid = 1'b0;
        checkValue("snoopRequest load", 32'(bus.snoopRequest), 32'b1011);
        checkValue("snoop grant held", 32'(bus.grant), 32'b0100);
        bus.snoopDone = 4'b0001;
        tick();
        checkValue("snoopRequest ack0", 32'(bus.snoopRequest), 32'b1010);
        checkValue("commandDone early0", 32'(bus.commandDone), 0);
        bus.snoopDone = 4'b1000;
        tick();
        checkValue("snoopRequest ack3", 32'(bus.snoopRequest), 32'b0010);
        checkValue("commandDone early3", 32'(bus.commandDone), 0);
        bus.snoopDone = 4'b0010;
        tick();
        bus.snoopDone = '0;
        checkValue("commandDone pulse", 32'(bus.commandDone), 1);
        checkValue("snoopRequest cleared", 32'(bus.snoopRequest), 0);
        tick();
        checkValue("commandDone one cycle", 32'(bus.commandDone), 0);
        checkValue("grant after snoop", 32'(bus.grant), 32'b0100);

        // all acks at once plus a stray owner ack; owner drop deferred
        bus.commandValid = 1'b1;
        tick();
        bus.commandValid = 1'b0;
        checkValue("snoopRequest reload", 32'(bus.snoopRequest), 32'b1011);
        bus.request   = '0;
        bus.snoopDone = 4'b1111;
        tick();
        bus.snoopDone = '0;
        checkValue("commandDone all acks", 32'(bus.commandDone), 1);
        checkValue("grant kept in snoop drop", 32'(bus.grant), 32'b0100);
        tick();
        checkValue("deferred release grant", 32'(bus.grant), 0);
        checkValue("deferred release commandDone", 32'(bus.commandDone), 0);
        checkValue("deferred release busBusy", 32'(bus.busBusy), 1);
        tick();
        checkValue("deferred idle busBusy", 32'(bus.busBusy), 0);

        // reset in the middle of SNOOP (pointer is 3 beforehand)
        bus.request = 4'b0100;
        tick();
        checkValue("pre-reset grant", 32'(bus.grant), 32'b0100);
        bus.commandValid = 1'b1;
        tick();
        bus.commandValid = 1'b0;
        bus.snoopDone    = 4'b0001;
        tick();
        bus.snoopDone = '0;
        checkValue("pre-reset pending", 32'(bus.snoopRequest), 32'b1010);
        #2;
        reset = 1'b0;
        #1;
        checkValue("async rst grant", 32'(bus.grant), 0);
        checkValue("async rst snoopRequest", 32'(bus.snoopRequest), 0);
        checkValue("async rst commandDone", 32'(bus.commandDone), 0);
        checkValue("async rst busBusy", 32'(bus.busBusy), 0);
        checkValue("async rst ownerId", 32'(bus.ownerId), 0);
        tick();
        tick();
        checkValue("rst held commandDone", 32'(bus.commandDone), 0);
        // a stale pointer of 3 would pick cache 3 here
        bus.request = 4'b1100;
        reset       = 1'b1;
        tick();
        checkValue("post-rst grant", 32'(bus.grant), 32'b0100);
        checkValue("post-rst ownerId", 32'(bus.ownerId), 2);
        checkValue("post-rst commandDone", 32'(bus.commandDone), 0);
        bus.request = '0;
        tick();
        tick();

`ifdef ARBITER_GRANT_COUNTERS_EN
        reset = 1'b0;
        tick();
        checkValue("counters cleared", 32'(grantCount), 0);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.request = 4'b0001;
            tick();
            bus.request = '0;
            tick();
            tick();
        end
        checkValue("grantCount0 saturated", 32'(grantCount[1:0]), 3);
        checkValue("grantCount others", 32'(grantCount[7:2]), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
